// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search scheduler and its decrypt cores.
package rc4_pkg;

    localparam int KEY_WIDTH      = 24;
    localparam int MESSAGE_LENGTH = 32;
    localparam int KEY_LENGTH     = 3;
    localparam int KEY_LIMIT      = 'h400000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_DRAIN,
        S_ABORT,
        S_FINISHED
    } sched_state_t;

endpackage

// File: rtl/rc4_key_search_scheduler_rr_arbiter.sv
// Round-robin request-to-one-hot grant; the pointer moves one past the last granted core.
module rr_arbiter #(
    parameter int NUM_CORES = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic [NUM_CORES-1:0] req,
    output logic [NUM_CORES-1:0] grant
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [PTR_W-1:0] rr;
    logic [PTR_W-1:0] rr_next;
    int               scan_idx;

    // Scanning from the far end down lets the final match be the first requester at or after rr.
    always_comb begin
        grant    = '0;
        rr_next  = rr;
        scan_idx = 0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            scan_idx = (int'(rr) + i) % NUM_CORES;
            if (req[scan_idx]) begin
                grant           = '0;
                grant[scan_idx] = 1'b1;
                rr_next         = PTR_W'((scan_idx + 1) % NUM_CORES);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rr <= '0;
        end else begin
            rr <= rr_next;
        end
    end

endmodule

// File: rtl/rc4_key_search_scheduler.sv
// Hands candidate keys to a bank of RC4 decrypt cores, stops on the first plaintext hit,
// and reports the winning key or exhaustion of the key space.
module rc4_key_search_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int KEY_WIDTH = rc4_pkg::KEY_WIDTH,
    parameter int KEY_LIMIT = rc4_pkg::KEY_LIMIT
) (
    input  logic                           CLOCK_50,
    input  logic                           reset_n,
    input  logic                           start,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic [NUM_CORES-1:0]           core_abort,
    input  logic [NUM_CORES-1:0]           core_busy,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_found,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [KEY_WIDTH-1:0]           next_key
);

    import rc4_pkg::*;

    // One extra bit so a limit of 2^KEY_WIDTH is reachable without wrapping.
    localparam logic [KEY_WIDTH:0] LIMIT = (KEY_WIDTH + 1)'(KEY_LIMIT);

    sched_state_t         state;
    logic [KEY_WIDTH:0]   key_q;
    logic [NUM_CORES-1:0] start_d2;
    logic                 abort_quiet;

    logic                 launch;
    logic                 hit_any;
    logic                 can_grant;
    logic [KEY_WIDTH:0]   issue_key;
    logic [NUM_CORES-1:0] hits;
    logic [NUM_CORES-1:0] idle_set;
    logic [NUM_CORES-1:0] grant;
    logic [KEY_WIDTH-1:0] hit_key;

    assign next_key  = key_q[KEY_WIDTH-1:0];
    assign launch    = start && (state == S_IDLE || state == S_FINISHED);
    assign hits      = core_done & core_found;
    assign hit_any   = (state == S_DISPATCH || state == S_DRAIN) && (|hits);
    assign issue_key = launch ? '0 : key_q;
    assign can_grant = (launch || state == S_DISPATCH) && !hit_any && (issue_key < LIMIT);
    // A core granted in the last two cycles may not have raised busy yet.
    assign idle_set  = ~core_busy & ~core_start & ~start_d2 & ~core_done;

    rr_arbiter #(
        .NUM_CORES(NUM_CORES)
    ) u_arbiter (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .req     (can_grant ? idle_set : '0),
        .grant   (grant)
    );

    always_comb begin
        hit_key = '0;
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            if (hits[c]) hit_key = core_key[c*KEY_WIDTH +: KEY_WIDTH];
        end
    end

    // NOTE: every register, including the key slices, clears asynchronously so outputs drop with reset_n.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            key_q       <= '0;
            core_start  <= '0;
            start_d2    <= '0;
            core_key    <= '0;
            core_abort  <= '0;
            abort_quiet <= 1'b0;
            busy        <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_key   <= '0;
        end else begin
            core_start <= grant;
            start_d2   <= core_start;
            for (int c = 0; c < NUM_CORES; c++) begin
                if (grant[c]) core_key[c*KEY_WIDTH +: KEY_WIDTH] <= issue_key[KEY_WIDTH-1:0];
            end
            if (|grant) begin
                key_q <= issue_key + 1'b1;
            end else if (launch) begin
                key_q <= '0;
            end

            if (hit_any) begin
                found       <= 1'b1;
                found_key   <= hit_key;
                core_abort  <= '1;
                abort_quiet <= 1'b0;
                state       <= S_ABORT;
            end else begin
                case (state)
                    S_IDLE, S_FINISHED: begin
                        if (start) begin
                            found     <= 1'b0;
                            exhausted <= 1'b0;
                            found_key <= '0;
                            busy      <= 1'b1;
                            state     <= S_DISPATCH;
                        end
                    end
                    S_DISPATCH: begin
                        if (key_q >= LIMIT) state <= S_DRAIN;
                    end
                    S_DRAIN: begin
                        if (core_busy == '0 && core_start == '0 && start_d2 == '0) begin
                            exhausted <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_FINISHED;
                        end
                    end
                    S_ABORT: begin
                        if (core_busy == '0) begin
                            if (abort_quiet) begin
                                core_abort  <= '0;
                                busy        <= 1'b0;
                                abort_quiet <= 1'b0;
                                state       <= S_FINISHED;
                            end else begin
                                abort_quiet <= 1'b1;
                            end
                        end else begin
                            abort_quiet <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rc4_key_search_scheduler.sv
// Directed bench: one scheduler with the full key space and one with KEY_LIMIT = 6,
// each driving a small behavioural core bank.
module tb_rc4_key_search_scheduler;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b1;
    int          checks   = 0;
    int          errors   = 0;

    logic        start, s_start;
    logic [3:0]  core_start, core_abort, core_done, core_found, busy_m;
    logic [3:0]  s_core_start, s_core_abort, s_core_done, s_core_found, s_busy_m;
    logic [95:0] core_key, s_core_key;
    logic        busy, found, exhausted, s_busy, s_found, s_exhausted;
    logic [23:0] found_key, next_key, s_found_key, s_next_key;
    int          s_grants;

    always #5 CLOCK_50 = ~CLOCK_50;

    rc4_key_search_scheduler #(.NUM_CORES(4), .KEY_WIDTH(24)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start),
        .core_start(core_start), .core_key(core_key), .core_abort(core_abort),
        .core_busy(busy_m), .core_done(core_done), .core_found(core_found),
        .busy(busy), .found(found), .exhausted(exhausted),
        .found_key(found_key), .next_key(next_key)
    );

    rc4_key_search_scheduler #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_LIMIT(6)) dut_lim (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(s_start),
        .core_start(s_core_start), .core_key(s_core_key), .core_abort(s_core_abort),
        .core_busy(s_busy_m), .core_done(s_core_done), .core_found(s_core_found),
        .busy(s_busy), .found(s_found), .exhausted(s_exhausted),
        .found_key(s_found_key), .next_key(s_next_key)
    );

    // Core bank: busy the cycle after a grant, free on done, cleared by abort.
    always @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            busy_m   <= '0;
            s_busy_m <= '0;
            s_grants <= 0;
        end else begin
            busy_m   <= (|core_abort)   ? 4'b0 : (busy_m | core_start) & ~core_done;
            s_busy_m <= (|s_core_abort) ? 4'b0 : (s_busy_m | s_core_start) & ~s_core_done;
            s_grants <= s_grants + $countones(s_core_start);
        end
    end

    function automatic logic [31:0] key_of(input logic [95:0] v, input int c);
        return {8'h0, v[c*24 +: 24]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit lim, input logic [3:0] d, input logic [3:0] f);
        if (lim) begin s_core_done = d; s_core_found = f; end
        else begin core_done = d; core_found = f; end
        @(negedge CLOCK_50);
        core_done = '0; core_found = '0; s_core_done = '0; s_core_found = '0;
    endtask

    task automatic free_core(input bit lim, input int c, input int exp_key);
        logic [3:0] m;
        m = 4'b0001 << c;
        pulse(lim, m, 4'b0000);
        check("no_grant_in_done_cycle", {28'h0, lim ? s_core_start : core_start}, 32'h0);
        @(negedge CLOCK_50);
        check("regrant_core", {28'h0, lim ? s_core_start : core_start}, {28'h0, m});
        check("regrant_key", key_of(lim ? s_core_key : core_key, c), exp_key);
    endtask

    task automatic wait_idle(input bit lim);
        for (int i = 0; i < 20; i++) begin
            if (!(lim ? s_busy : busy)) break;
            check("abort_held_while_busy", {28'h0, lim ? s_core_abort : core_abort}, 32'hf);
            @(negedge CLOCK_50);
        end
        check("search_stops", {31'h0, lim ? s_busy : busy}, 32'h0);
    endtask

    initial begin
        start = 0; s_start = 0;
        core_done = '0; core_found = '0; s_core_done = '0; s_core_found = '0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_core_start", {28'h0, core_start}, 32'h0);
        check("rst_next_key", {8'h0, next_key}, 32'h0);
        check("rst_flags", {29'h0, busy, found, exhausted}, 32'h0);
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;

        // Fresh search: cores 0..3 take keys 0..3 on consecutive cycles.
        @(negedge CLOCK_50); start = 1;
        @(negedge CLOCK_50); start = 0;
        check("grant0", {28'h0, core_start}, 32'h1);
        check("key0", key_of(core_key, 0), 32'd0);
        check("busy_up", {31'h0, busy}, 32'h1);
        @(negedge CLOCK_50);
        check("grant1", {28'h0, core_start}, 32'h2);
        check("key1", key_of(core_key, 1), 32'd1);
        @(negedge CLOCK_50);
        check("grant2", {28'h0, core_start}, 32'h4);
        check("key2", key_of(core_key, 2), 32'd2);
        @(negedge CLOCK_50);
        check("grant3", {28'h0, core_start}, 32'h8);
        check("key3", key_of(core_key, 3), 32'd3);
        check("next_key4", {8'h0, next_key}, 32'd4);
        start = 1;
        @(negedge CLOCK_50); start = 0;
        check("start_ignored_grant", {28'h0, core_start}, 32'h0);
        check("start_ignored_key", {8'h0, next_key}, 32'd4);

        // Core 2 finishes without a hit and picks up key 4.
        free_core(0, 2, 4);
        check("next_key5", {8'h0, next_key}, 32'd5);

        // Steer key 9 onto core 1 and key 11 onto core 3.
        free_core(0, 0, 5);
        free_core(0, 2, 6);
        free_core(0, 3, 7);
        free_core(0, 0, 8);
        free_core(0, 1, 9);
        free_core(0, 2, 10);
        free_core(0, 3, 11);
        @(negedge CLOCK_50);
        pulse(0, 4'b1010, 4'b1010);
        check("hit_found", {31'h0, found}, 32'h1);
        check("hit_lowest_key", {8'h0, found_key}, 32'd9);
        check("hit_abort", {28'h0, core_abort}, 32'hf);
        check("hit_no_exhaust", {31'h0, exhausted}, 32'h0);
        pulse(0, 4'b0001, 4'b0001);
        check("late_hit_ignored", {8'h0, found_key}, 32'd9);
        wait_idle(0);
        check("abort_dropped", {28'h0, core_abort}, 32'h0);
        check("final_found", {31'h0, found}, 32'h1);
        check("final_found_key", {8'h0, found_key}, 32'd9);

        // KEY_LIMIT = 6 with no hits: six grants, drain, exhausted after the last done.
        @(negedge CLOCK_50); s_start = 1;
        @(negedge CLOCK_50); s_start = 0;
        check("lim_grant0", {28'h0, s_core_start}, 32'h1);
        repeat (3) @(negedge CLOCK_50);
        check("lim_next_key4", {8'h0, s_next_key}, 32'd4);
        free_core(1, 0, 4);
        free_core(1, 1, 5);
        @(negedge CLOCK_50);
        check("lim_drain_no_grant", {28'h0, s_core_start}, 32'h0);
        check("lim_next_key6", {8'h0, s_next_key}, 32'd6);
        pulse(1, 4'b1101, 4'b0000);
        check("lim_not_yet_exhausted", {31'h0, s_exhausted}, 32'h0);
        pulse(1, 4'b0010, 4'b0000);
        check("lim_exhaust_lag", {31'h0, s_exhausted}, 32'h0);
        @(negedge CLOCK_50);
        check("lim_exhausted", {31'h0, s_exhausted}, 32'h1);
        check("lim_found_clear", {31'h0, s_found}, 32'h0);
        check("lim_idle", {31'h0, s_busy}, 32'h0);
        check("lim_six_grants", s_grants, 32'd6);

        // Restart from finished (pointer sits at core 2); hit on key 5 during drain.
        s_start = 1;
        @(negedge CLOCK_50); s_start = 0;
        check("re_grant_core2", {28'h0, s_core_start}, 32'h4);
        check("re_key0", key_of(s_core_key, 2), 32'd0);
        check("re_exhaust_clear", {31'h0, s_exhausted}, 32'h0);
        repeat (3) @(negedge CLOCK_50);
        free_core(1, 2, 4);
        free_core(1, 3, 5);
        @(negedge CLOCK_50);
        pulse(1, 4'b1000, 4'b1000);
        check("drain_hit_found", {31'h0, s_found}, 32'h1);
        check("drain_hit_key", {8'h0, s_found_key}, 32'd5);
        wait_idle(1);
        check("drain_hit_not_exhausted", {31'h0, s_exhausted}, 32'h0);
        check("drain_hit_found_held", {31'h0, s_found}, 32'h1);

        // Reset mid-dispatch clears outputs without a clock edge.
        @(negedge CLOCK_50); start = 1;
        @(negedge CLOCK_50); start = 0;
        @(negedge CLOCK_50);
        check("pre_reset_busy", {31'h0, busy}, 32'h1);
        @(posedge CLOCK_50);
        #2 reset_n = 1'b0;
        #1;
        check("async_core_start", {28'h0, core_start}, 32'h0);
        check("async_core_key", {31'h0, |core_key}, 32'h0);
        check("async_next_key", {8'h0, next_key}, 32'h0);
        check("async_flags", {29'h0, busy, found, exhausted}, 32'h0);
        check("async_lim_found_key", {8'h0, s_found_key}, 32'h0);
        check("async_lim_flags", {28'h0, s_core_abort == 4'h0 ? 1'b0 : 1'b1, s_busy, s_found, s_exhausted}, 32'h0);
        @(negedge CLOCK_50); reset_n = 1'b1;
        @(negedge CLOCK_50); start = 1;
        @(negedge CLOCK_50); start = 0;
        check("post_reset_grant", {28'h0, core_start}, 32'h1);
        check("post_reset_key0", key_of(core_key, 0), 32'd0);
        check("post_reset_next_key", {8'h0, next_key}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc4_key_search_scheduler.md
Name: rc4_key_search_scheduler

Overview:
- Sequences a bank of NUM_CORES RC4 decrypt cores, each running KSA init, KSA swap, PRGA and 32-byte decrypt for one 24-bit secret key.
- Hands out candidate keys from 0 upward, one grant per cycle, to idle cores.
- Collects done/found reports, stops the whole search on the first hit, and reports the winning key or exhaustion.
- Sits between the board top (CLOCK_50, KEY, SW, LEDR) and the core array.

Parameters:
- NUM_CORES, 4, number of decrypt cores; must be ≥1 and a power of two.
- KEY_WIDTH, 24, secret key width.
- KEY_LIMIT, 24'h400000, exclusive upper bound of the search space; the top 2 key bits are always zero.

Ports:
- CLOCK_50  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset, driven from KEY[3]
- start  in  1  one-cycle pulse that begins a search; ignored unless state is S_IDLE or S_FINISHED
- core_start  out  NUM_CORES  one-cycle grant pulse per core
- core_key  out  NUM_CORES*KEY_WIDTH  per-core key slice; holds its value while the core is busy
- core_abort  out  NUM_CORES  level; while high, a core returns to idle within 2 cycles without reporting
- core_busy  in  NUM_CORES  core is running a key
- core_done  in  NUM_CORES  one-cycle pulse when a core finishes its key
- core_found  in  NUM_CORES  qualified by core_done; all 32 decrypted bytes are in 'a'..'z' or space
- busy  out  1  search in progress
- found  out  1  search ended with a hit
- exhausted  out  1  search ended with no hit
- found_key  out  KEY_WIDTH  winning key
- next_key  out  KEY_WIDTH  next key to issue; drives the LEDR progress display

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = S_IDLE.
  - All outputs 0: core_start, core_key, core_abort, busy, found, exhausted, found_key, next_key.
  - The round-robin pointer rr = 0.
- States:
  - S_IDLE:
    - On start: next_key ← 0, clear found/exhausted/found_key, busy ← 1, go to S_DISPATCH.
  - S_DISPATCH, each cycle:
    - Idle set = cores with !core_busy, not granted in the previous 2 cycles (covers the core's busy-raise latency), and not pulsing done this cycle.
    - If the idle set is non-empty and next_key < KEY_LIMIT, grant exactly one core: the first idle core at or after rr, scanning rr, rr+1, … mod NUM_CORES.
    - On a grant: core_key[c] ← next_key and core_start[c] = 1 in the same registered cycle; next_key ← next_key+1; rr ← c+1 mod NUM_CORES.
    - When next_key == KEY_LIMIT, stop granting and go to S_DRAIN.
  - S_DRAIN:
    - No grants.
    - When core_busy == 0 and no grant is outstanding, go to S_FINISHED with exhausted ← 1.
  - S_ABORT:
    - core_abort = all-ones.
    - When core_busy == 0 for 2 consecutive cycles, drop core_abort and go to S_FINISHED.
  - S_FINISHED:
    - busy = 0; found/exhausted/found_key hold their values.
    - On start: begin a new search exactly as from S_IDLE.
- Hit handling, in S_DISPATCH or S_DRAIN:
  - Any cycle with (core_done & core_found) != 0 is a hit.
  - Capture found_key ← core_key of the lowest-index reporting core, set found ← 1, go to S_ABORT.
  - This applies even if a grant would otherwise happen that cycle; the grant is suppressed.
  - Any later done/found pulses are ignored; found_key never changes after capture.
  - core_done without core_found only frees the core.
- Boundaries:
  - A hit on key KEY_LIMIT-1 that arrives in S_DRAIN reports found, not exhausted.
  - next_key is KEY_WIDTH+1 bits internally so KEY_LIMIT == 2^KEY_WIDTH cannot wrap; the next_key output is the low KEY_WIDTH bits.
  - start while busy is ignored.
  - A reset mid-search returns to S_IDLE; cores are expected to share the same reset.
- Latency: start → first core_start is 1 cycle; a core_done/core_found hit → found=1 is 1 cycle.
- Width rules: key arithmetic is unsigned; key slice c occupies core_key[(c+1)*KEY_WIDTH-1 : c*KEY_WIDTH].

Decomposition:
- Package rc4_pkg holds:
  - enum sched_state_t {S_IDLE, S_DISPATCH, S_DRAIN, S_ABORT, S_FINISHED};
  - constants KEY_WIDTH = 24, MESSAGE_LENGTH = 32, KEY_LENGTH = 3, KEY_LIMIT.
- One sub-module, rr_arbiter:
  - Parameterised on NUM_CORES; combinational request→one-hot grant with registered rr pointer update.
  - Used for idle-core selection; the lowest-index hit priority is a separate fixed priority encoder.

Test Plan:
- NUM_CORES=4, all cores idle, start:
  - core_start grants cores 0,1,2,3 in order with keys 0,1,2,3; next_key = 4; rr wraps back to 0.
- Core 2 pulses done with found=0 at key 2 while others stay busy:
  - core 2 is regranted with key 4 one cycle later.
- Cores 1 (key 9) and 3 (key 11) pulse done+found in the same cycle:
  - found=1 and found_key=9 one cycle later; core_abort = 4'b1111 until busy clears; then busy=0.
- KEY_LIMIT overridden to 6, no hits:
  - exactly 6 grants (keys 0..5), then S_DRAIN; exhausted=1 only after the last core_done; found stays 0.
- KEY_LIMIT=6 with a hit on key 5 during drain:
  - found=1, found_key=5, exhausted=0.
- Assert reset_n low mid-dispatch:
  - all outputs 0 immediately, without a clock edge; start after release restarts from key 0.
